// File: rtl/rect_matrix_accel_pkg.sv
// Shared types and helpers for the rectangular matrix accelerator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rect_matrix_accel_pkg;

  // Working width for intermediate sums; accumulators up to 62 bits fit without loss.
  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Address/counter width for n entries; never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sign-extend the low w bits of v to MAXW bits.
  function automatic logic signed [MAXW-1:0] sext(input logic [MAXW-1:0] v, input int w);
    logic signed [MAXW-1:0] t;
    t = $signed(v << (MAXW - w));
    return t >>> (MAXW - w);
  endfunction

  // Largest signed value representable in w bits.
  function automatic logic signed [MAXW-1:0] acc_max(input int w);
    logic signed [MAXW-1:0] one;
    one = {{(MAXW-1){1'b0}}, 1'b1};
    return (one <<< (w - 1)) - one;
  endfunction

  // True when s does not fit in a w-bit signed value.
  function automatic logic sat_hit(input logic signed [MAXW-1:0] s, input int w);
    return (s > acc_max(w)) || (s < ~acc_max(w));
  endfunction

  // Clamp s to the w-bit signed range.
  function automatic logic signed [MAXW-1:0] sat_clamp(input logic signed [MAXW-1:0] s, input int w);
    if (s > acc_max(w)) return acc_max(w);
    if (s < ~acc_max(w)) return ~acc_max(w);
    return s;
  endfunction

endpackage

// File: rtl/rect_matrix_accelerator_mac_unit.sv
// Signed multiply-accumulate step: product of a and b added to a seed or the running sum.
// Latency: sum is combinational; the running accumulator updates on the enabled edge.
// Backpressure: none, advances whenever i_en is high. Clamps instead of wrapping when SATURATE_EN is defined.
module mac_unit
  import rect_matrix_accel_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 40
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_en,
  input  logic                          i_first,
  input  logic signed [ACCUM_WIDTH-1:0] i_seed,
  input  logic signed [DATA_WIDTH-1:0]  i_a,
  input  logic signed [DATA_WIDTH-1:0]  i_b,
  output logic signed [ACCUM_WIDTH-1:0] o_sum,
  output logic                          o_ovf
);

  logic signed [ACCUM_WIDTH-1:0]  r_acc;
  logic signed [ACCUM_WIDTH-1:0]  w_base;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [MAXW-1:0]         w_prod_ext;
  logic signed [MAXW-1:0]         w_sum_full;
  logic signed [MAXW-1:0]         w_sum_out;

  // Full-precision product plus base, then wrap or clamp to the accumulator width.
  always_comb begin
    w_base     = i_first ? i_seed : r_acc;
    w_prod     = (2*DATA_WIDTH)'(i_a) * (2*DATA_WIDTH)'(i_b);
    w_prod_ext = sext(MAXW'(unsigned'(w_prod)), 2*DATA_WIDTH);
    w_sum_full = MAXW'(w_base) + w_prod_ext;
`ifdef SATURATE_EN
    w_sum_out  = sat_clamp(w_sum_full, ACCUM_WIDTH);
    o_ovf      = sat_hit(w_sum_full, ACCUM_WIDTH);
`else
    w_sum_out  = w_sum_full;
    o_ovf      = 1'b0;
`endif
    o_sum      = w_sum_out[ACCUM_WIDTH-1:0];
  end

  // Running partial sum carried between inner-loop steps.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/rect_matrix_accelerator.sv
// Computes C = A x B (or C += A x B) over internal A/B/C register arrays, one MAC per clock.
// Latency: busy after the start edge, done M*P*K edges later; C reads are registered (1 cycle).
// Backpressure: start and A/B writes are dropped while busy. SATURATE_EN enables clamping and the overflow flag.
module rect_matrix_accelerator
  import rect_matrix_accel_pkg::*;
#(
  parameter int M           = 4,
  parameter int K           = 4,
  parameter int P           = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 40
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          accumulate,
  input  logic                          write_a_en,
  input  logic [cw(M*K)-1:0]            write_a_addr,
  input  logic signed [DATA_WIDTH-1:0]  write_a_data,
  input  logic                          write_b_en,
  input  logic [cw(K*P)-1:0]            write_b_addr,
  input  logic signed [DATA_WIDTH-1:0]  write_b_data,
  input  logic [cw(M*P)-1:0]            read_addr,
  output logic signed [ACCUM_WIDTH-1:0] read_data_c,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int AAW = cw(M*K);
  localparam int BAW = cw(K*P);
  localparam int CAW = cw(M*P);
  localparam int IW  = cw(M);
  localparam int JW  = cw(P);
  localparam int KW  = cw(K);

  logic signed [DATA_WIDTH-1:0]  r_a [M*K];
  logic signed [DATA_WIDTH-1:0]  r_b [K*P];
  logic signed [ACCUM_WIDTH-1:0] r_c [M*P];

  state_t          r_state;
  logic [IW-1:0]   r_i;
  logic [JW-1:0]   r_j;
  logic [KW-1:0]   r_k;
  logic            r_accum_mode;
  logic            r_busy;
  logic            r_done;
  logic            r_overflow;

  logic [AAW-1:0]                w_a_idx;
  logic [BAW-1:0]                w_b_idx;
  logic [CAW-1:0]                w_c_idx;
  logic                          w_mac_en;
  logic                          w_first;
  logic                          w_last_i;
  logic                          w_last_j;
  logic                          w_last_k;
  logic signed [ACCUM_WIDTH-1:0] w_seed;
  logic signed [ACCUM_WIDTH-1:0] w_sum;
  logic                          w_mac_ovf;

  // Operand/result addresses for the current (i, j, k) step, row-major.
  always_comb begin
    w_a_idx  = AAW'(int'(r_i) * K + int'(r_k));
    w_b_idx  = BAW'(int'(r_k) * P + int'(r_j));
    w_c_idx  = CAW'(int'(r_i) * P + int'(r_j));
    w_mac_en = (r_state == S_COMPUTE);
    w_first  = (int'(r_k) == 0);
    w_last_i = (int'(r_i) == M - 1);
    w_last_j = (int'(r_j) == P - 1);
    w_last_k = (int'(r_k) == K - 1);
    w_seed   = r_accum_mode ? r_c[w_c_idx] : '0;
  end

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACCUM_WIDTH(ACCUM_WIDTH)
  ) u_mac (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_en     (w_mac_en),
    .i_first  (w_first),
    .i_seed   (w_seed),
    .i_a      (r_a[w_a_idx]),
    .i_b      (r_b[w_b_idx]),
    .o_sum    (w_sum),
    .o_ovf    (w_mac_ovf)
  );

  // Control FSM: walks i/j/k in row-major order and owns busy/done/overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_accum_mode <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_COMPUTE;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_accum_mode <= accumulate;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
          end
        end
        S_COMPUTE: begin
          // Stays 0 without SATURATE_EN because the MAC never reports a clamp.
          r_overflow <= r_overflow | w_mac_ovf;
          if (w_last_k) begin
            r_k <= '0;
            if (w_last_j) begin
              r_j <= '0;
              if (w_last_i) begin
                r_i     <= '0;
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand loads while idle, and C write-back on the last inner step of each element.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int n = 0; n < M*K; n++) r_a[n] <= '0;
      for (int n = 0; n < K*P; n++) r_b[n] <= '0;
      for (int n = 0; n < M*P; n++) r_c[n] <= '0;
    end else begin
      if (write_a_en && !r_busy && (int'(write_a_addr) < M*K)) r_a[write_a_addr] <= write_a_data;
      if (write_b_en && !r_busy && (int'(write_b_addr) < K*P)) r_b[write_b_addr] <= write_b_data;
      if (w_mac_en && w_last_k) r_c[w_c_idx] <= w_sum;
    end
  end

  // Registered C read port; out-of-range addresses read as zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_data_c <= '0;
    end else if (int'(read_addr) < M*P) begin
      read_data_c <= r_c[read_addr];
    end else begin
      read_data_c <= '0;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_rect_matrix_accelerator.sv
// Directed bench for rect_matrix_accelerator: three instances (4x4x4, 2x3x2, 4x4x4 with 32-bit accumulator).
// Expected C values are hand-computed constants held in a vector table.
// Saturation expectations follow the SATURATE_EN build option.
module tb_rect_matrix_accelerator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic accumulate = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default 4x4x4, 40-bit accumulator
  logic              s0_start = 0, s0_wa_en = 0, s0_wb_en = 0;
  logic [3:0]        s0_wa_addr = 0, s0_wb_addr = 0, s0_rd_addr = 0;
  logic signed [15:0] s0_wa_dat = 0, s0_wb_dat = 0;
  logic signed [39:0] s0_rd;
  logic              s0_busy, s0_done, s0_ovf;

  // Instance 1: M=2, K=3, P=2
  logic              s1_start = 0, s1_wa_en = 0, s1_wb_en = 0;
  logic [2:0]        s1_wa_addr = 0, s1_wb_addr = 0;
  logic [1:0]        s1_rd_addr = 0;
  logic signed [15:0] s1_wa_dat = 0, s1_wb_dat = 0;
  logic signed [39:0] s1_rd;
  logic              s1_busy, s1_done, s1_ovf;

  // Instance 2: 4x4x4, 32-bit accumulator
  logic              s2_start = 0, s2_wa_en = 0, s2_wb_en = 0;
  logic [3:0]        s2_wa_addr = 0, s2_wb_addr = 0, s2_rd_addr = 0;
  logic signed [15:0] s2_wa_dat = 0, s2_wb_dat = 0;
  logic signed [31:0] s2_rd;
  logic              s2_busy, s2_done, s2_ovf;

  rect_matrix_accelerator d0 (
    .clk(clk), .reset_n(reset_n), .start(s0_start), .accumulate(accumulate),
    .write_a_en(s0_wa_en), .write_a_addr(s0_wa_addr), .write_a_data(s0_wa_dat),
    .write_b_en(s0_wb_en), .write_b_addr(s0_wb_addr), .write_b_data(s0_wb_dat),
    .read_addr(s0_rd_addr), .read_data_c(s0_rd),
    .busy(s0_busy), .done(s0_done), .overflow(s0_ovf));

  rect_matrix_accelerator #(.M(2), .K(3), .P(2)) d1 (
    .clk(clk), .reset_n(reset_n), .start(s1_start), .accumulate(accumulate),
    .write_a_en(s1_wa_en), .write_a_addr(s1_wa_addr), .write_a_data(s1_wa_dat),
    .write_b_en(s1_wb_en), .write_b_addr(s1_wb_addr), .write_b_data(s1_wb_dat),
    .read_addr(s1_rd_addr), .read_data_c(s1_rd),
    .busy(s1_busy), .done(s1_done), .overflow(s1_ovf));

  rect_matrix_accelerator #(.ACCUM_WIDTH(32)) d2 (
    .clk(clk), .reset_n(reset_n), .start(s2_start), .accumulate(accumulate),
    .write_a_en(s2_wa_en), .write_a_addr(s2_wa_addr), .write_a_data(s2_wa_dat),
    .write_b_en(s2_wb_en), .write_b_addr(s2_wb_addr), .write_b_data(s2_wb_dat),
    .read_addr(s2_rd_addr), .read_data_c(s2_rd),
    .busy(s2_busy), .done(s2_done), .overflow(s2_ovf));

`ifdef SATURATE_EN
  localparam longint SAT_EXP = 64'sd2147483647;
  localparam logic   OVF_EXP = 1'b1;
`else
  localparam longint SAT_EXP = -64'sd262140;
  localparam logic   OVF_EXP = 1'b0;
`endif

  typedef struct {
    int     phase;
    int     inst;
    int     addr;
    longint exp;
    string  name;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int inst, input int sel, input int addr, input int data);
    @(negedge clk);
    case (inst)
      0: if (sel == 0) begin s0_wa_en = 1; s0_wa_addr = 4'(addr); s0_wa_dat = 16'(data); end
         else begin s0_wb_en = 1; s0_wb_addr = 4'(addr); s0_wb_dat = 16'(data); end
      1: if (sel == 0) begin s1_wa_en = 1; s1_wa_addr = 3'(addr); s1_wa_dat = 16'(data); end
         else begin s1_wb_en = 1; s1_wb_addr = 3'(addr); s1_wb_dat = 16'(data); end
      default: if (sel == 0) begin s2_wa_en = 1; s2_wa_addr = 4'(addr); s2_wa_dat = 16'(data); end
         else begin s2_wb_en = 1; s2_wb_addr = 4'(addr); s2_wb_dat = 16'(data); end
    endcase
    @(posedge clk); #1;
    s0_wa_en = 0; s0_wb_en = 0; s1_wa_en = 0; s1_wb_en = 0; s2_wa_en = 0; s2_wb_en = 0;
  endtask

  task automatic rd(input int inst, input int addr, output logic signed [63:0] v);
    @(negedge clk);
    case (inst)
      0: s0_rd_addr = 4'(addr);
      1: s1_rd_addr = 2'(addr);
      default: s2_rd_addr = 4'(addr);
    endcase
    @(posedge clk); #1;
    case (inst)
      0: v = 64'(s0_rd);
      1: v = 64'(s1_rd);
      default: v = 64'(s2_rd);
    endcase
  endtask

  function automatic logic get_done(input int inst);
    case (inst)
      0: return s0_done;
      1: return s1_done;
      default: return s2_done;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0: return s0_busy;
      1: return s1_busy;
      default: return s2_busy;
    endcase
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: s0_start = v;
      1: s1_start = v;
      default: s2_start = v;
    endcase
  endtask

  // Start a run and count edges after the start edge until done is seen.
  // disturb: on instance 0, pulse start and write A[0]=100 mid-run.
  // prewrite: on instance 1, write A[0]=1 in the same cycle as start.
  task automatic run(input int inst, input logic acc, input bit disturb, input bit prewrite, output int edges);
    @(negedge clk);
    accumulate = acc;
    set_start(inst, 1'b1);
    if (prewrite) begin s1_wa_en = 1; s1_wa_addr = 3'd0; s1_wa_dat = 16'sd1; end
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    s1_wa_en = 0;
    chk("busy_after_start", 64'(get_busy(inst)), 64'd1);
    chk("done_cleared_on_start", 64'(get_done(inst)), 64'd0);
    edges = 0;
    while (!get_done(inst) && edges < 2000) begin
      if (disturb && edges == 2) begin
        s0_start = 1; s0_wa_en = 1; s0_wa_addr = 4'd0; s0_wa_dat = 16'sd100;
      end else if (disturb && edges == 3) begin
        s0_start = 0; s0_wa_en = 0;
      end
      @(posedge clk); #1;
      edges++;
    end
    s0_start = 0; s0_wa_en = 0;
    chk("busy_low_at_done", 64'(get_busy(inst)), 64'd0);
  endtask

  task automatic check_phase(input int ph);
    logic signed [63:0] v;
    for (int n = 0; n < NV; n++) begin
      if (vt[n].phase == ph) begin
        rd(vt[n].inst, vt[n].addr, v);
        chk(vt[n].name, v, vt[n].exp);
      end
    end
  endtask

  initial begin
    int edges;
    // phase, instance, C address, expected value, name
    vt[0]  = '{0, 0, 0,  0,    "reset_c00"};
    vt[1]  = '{0, 0, 15, 0,    "reset_c33"};
    vt[2]  = '{1, 0, 0,  56,   "t1_c00"};
    vt[3]  = '{1, 0, 1,  62,   "t1_c01"};
    vt[4]  = '{1, 0, 6,  196,  "t1_c12"};
    vt[5]  = '{1, 0, 8,  248,  "t1_c20"};
    vt[6]  = '{1, 0, 13, 398,  "t1_c31"};
    vt[7]  = '{1, 0, 15, 506,  "t1_c33"};
    vt[8]  = '{2, 0, 0,  112,  "t2_c00"};
    vt[9]  = '{2, 0, 1,  124,  "t2_c01"};
    vt[10] = '{2, 0, 6,  392,  "t2_c12"};
    vt[11] = '{2, 0, 8,  496,  "t2_c20"};
    vt[12] = '{2, 0, 13, 796,  "t2_c31"};
    vt[13] = '{2, 0, 15, 1012, "t2_c33"};
    vt[14] = '{3, 1, 0,  58,   "t3_c00"};
    vt[15] = '{3, 1, 1,  64,   "t3_c01"};
    vt[16] = '{3, 1, 2,  139,  "t3_c10"};
    vt[17] = '{3, 1, 3,  154,  "t3_c11"};
    vt[18] = '{4, 2, 0,  SAT_EXP, "t4_c00"};
    vt[19] = '{4, 2, 5,  SAT_EXP, "t4_c11"};
    vt[20] = '{4, 2, 10, SAT_EXP, "t4_c22"};
    vt[21] = '{4, 2, 15, SAT_EXP, "t4_c33"};
    vt[22] = '{5, 0, 0,  0,    "t5_c00"};
    vt[23] = '{5, 0, 5,  0,    "t5_c11"};
    vt[24] = '{5, 0, 15, 0,    "t5_c33"};
    vt[25] = '{5, 2, 15, 0,    "t5_d2_c33"};

    // Reset
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    chk("reset_busy", 64'(s0_busy), 64'd0);
    chk("reset_done", 64'(s0_done), 64'd0);
    chk("reset_ovf", 64'(s0_ovf), 64'd0);
    check_phase(0);

    // Test 1: A[i]=B[i]=i, plain multiply, with an ignored start/write mid-run
    for (int n = 0; n < 16; n++) begin
      wr(0, 0, n, n);
      wr(0, 1, n, n);
    end
    run(0, 1'b0, 1'b1, 1'b0, edges);
    chk("t1_done_edges", 64'(edges), 64'd64);
    chk("t1_ovf", 64'(s0_ovf), 64'd0);
    check_phase(1);

    // Test 2: same data, accumulate
    run(0, 1'b1, 1'b0, 1'b0, edges);
    chk("t2_done_edges", 64'(edges), 64'd64);
    check_phase(2);

    // Test 3: 2x3 * 3x2; A[0] preloaded wrong, corrected in the start cycle
    wr(1, 0, 0, 50);
    for (int n = 1; n < 6; n++) wr(1, 0, n, n + 1);
    for (int n = 0; n < 6; n++) wr(1, 1, n, n + 7);
    run(1, 1'b0, 1'b0, 1'b1, edges);
    chk("t3_done_edges", 64'(edges), 64'd12);
    check_phase(3);

    // Test 4: 32-bit accumulator overflow, all operands 32767
    for (int n = 0; n < 16; n++) begin
      wr(2, 0, n, 32767);
      wr(2, 1, n, 32767);
    end
    run(2, 1'b0, 1'b0, 1'b0, edges);
    chk("t4_done_edges", 64'(edges), 64'd64);
    chk("t4_ovf", 64'(s2_ovf), 64'(OVF_EXP));
    check_phase(4);

    // Test 5: reset on cycle 10 of a compute aborts it
    @(negedge clk);
    accumulate = 0;
    s0_start = 1;
    @(posedge clk); #1;
    s0_start = 0;
    repeat (10) @(posedge clk);
    @(negedge clk) reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    chk("t5_busy", 64'(s0_busy), 64'd0);
    chk("t5_done", 64'(s0_done), 64'd0);
    chk("t5_d2_ovf", 64'(s2_ovf), 64'd0);
    repeat (80) @(posedge clk);
    #1;
    chk("t5_done_stays_low", 64'(s0_done), 64'd0);
    check_phase(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rect_matrix_accelerator.md
# rect_matrix_accelerator

Parametrised successor to the square matrix accelerator: computes C[M×P] = A[M×K] × B[K×P] (or C += A×B in accumulate mode) on signed fixed-point operands, using one multiply-accumulate per clock. Holds A, B, C in internal register arrays loaded and read over simple address/data ports. A start/busy/done handshake lets a host or DMA sequencer own it. Sits where the fixed N×N top-level accelerator sits today.

## Interface
- M, 4, rows of A and C
- K, 4, columns of A / rows of B (inner dimension)
- P, 4, columns of B and C
- DATA_WIDTH, 16, signed operand width
- ACCUM_WIDTH, 40, signed accumulator and C element width (≥ 2*DATA_WIDTH)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request computation; accepted only when busy=0
- accumulate  in  1  sampled with accepted start: 1 = C += A×B, 0 = C = A×B
- write_a_en  in  1  write enable for A
- write_a_addr  in  $clog2(M*K)  row-major A index
- write_a_data  in  DATA_WIDTH  signed A element
- write_b_en  in  1  write enable for B
- write_b_addr  in  $clog2(K*P)  row-major B index
- write_b_data  in  DATA_WIDTH  signed B element
- read_addr  in  $clog2(M*P)  row-major C index
- read_data_c  out  ACCUM_WIDTH  registered C element
- busy  out  1  computation in progress
- done  out  1  sticky completion flag
- overflow  out  1  sticky saturation flag (see Configuration)

## Operation
- FSM states: IDLE, COMPUTE, DONE. IDLE/DONE --start--> COMPUTE (clears done, overflow; latches accumulate). COMPUTE --last MAC--> DONE. DONE holds until next start.
- Loop order row-major: i over M, j over P, k innermost over K; one MAC per cycle.
- Per element: accumulator seeded with C[i][j] (accumulate=1) or 0 on k=0; on k=K-1 the final sum is written to C[i][j] that same edge.
- Product: full 2*DATA_WIDTH signed, sign-extended to ACCUM_WIDTH; sums wrap modulo 2^ACCUM_WIDTH (without macro).
- Writes to A/B with busy=1 are dropped. Simultaneous A and B writes allowed. Out-of-range write addresses ignored.
- start with busy=1 ignored. start and write in the same cycle while idle: write lands, compute uses the new value.
- Reads allowed any time; during COMPUTE return partially updated C. Out-of-range read returns 0.
- Reset: FSM→IDLE; busy, done, overflow, read_data_c = 0; A, B, C arrays cleared to 0. Reset mid-COMPUTE aborts with no done.

## Timing
- start sampled at edge E; busy=1 after E; MAC cycles on edges E+1 … E+M*P*K; after edge E+M*P*K busy=0 and done=1 simultaneously.
- C[i][j] updated on edge E+((i*P+j)+1)*K.
- read_data_c valid one cycle after read_addr presented (registered).
- Write latency: one edge; value readable by compute from the next cycle.

## Configuration
- SATURATE_EN defined: every accumulate step clamps to [-2^(ACCUM_WIDTH-1), 2^(ACCUM_WIDTH-1)-1]; any clamp sets overflow (sticky until next accepted start or reset).
- Undefined: two's-complement wrap; overflow tied to 0.

## Structure
- Package rect_matrix_accel_pkg: FSM state enum, saturate/sign-extend functions, address-width helpers.
- One sub-module: mac_unit (signed multiply, extend, add with optional saturation; combinational result, registered accumulator).

## Test plan
- Defaults, A[i]=B[i]=i (i=0..15), accumulate=0 -> C[0][0]=56, C[3][3]=506; done rises exactly 64 edges after start edge.
- Rerun same data with accumulate=1 -> C[0][0]=112, C[3][3]=1012; done was cleared on start.
- M=2,K=3,P=2, A=[1 2 3;4 5 6], B=[7 8;9 10;11 12] -> C=[58 64;139 154]; done 12 edges after start.
- During test-1 compute, pulse start and write A[0]=100 -> ignored; results and done timing identical to test 1.
- reset_n low at cycle 10 of compute -> busy=0, done=0, every C read returns 0.
- ACCUM_WIDTH=32, all A,B=32767: SATURATE_EN -> every C=2147483647, overflow=1; without -> every C=-262140, overflow=0.
